// File: rtl/dl166_pkg.sv
// Shared DL166 definitions: run-controller state encoding,
// bus widths and the opcode field used by the core.
package dl166_pkg;

  localparam int IW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_HALT = 2'd1,
    ST_RUN  = 2'd2,
    ST_STEP = 2'd3
  } st_e;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_LD  = 4'h6;
  localparam logic [3:0] OP_ST  = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_OUT = 4'hA;

  function automatic logic [3:0] opcode(
    input logic [IW-1:0] ins
  );
    return ins[IW-1 -: 4];
  endfunction

endpackage

// File: rtl/dl166_prog_ram.sv
// 16x8 program memory: one synchronous write port, one
// asynchronous read port, cleared synchronously on reset.
module dl166_prog_ram
  import dl166_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem_q [DEPTH];
  logic [IW-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dl166_run_ctrl.sv
// DL166 run/debug controller: reset-hold, halt, run and
// single-step sequencing plus the shared program memory.
module dl166_run_ctrl
  import dl166_pkg::*;
#(
  parameter int RST_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_run,
  input  logic          cmd_halt,
  input  logic          cmd_step,
  input  logic          cmd_rst_cpu,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [IW-1:0] ld_data,
  input  logic          bp_en,
  input  logic [AW-1:0] bp_addr,
  input  logic [AW-1:0] cpu_adr,
  output logic [IW-1:0] cpu_dout,
  output logic          cpu_ce,
  output logic          cpu_rst_n,
  output logic [1:0]    state,
  output logic [15:0]   retired
);

  localparam int CW =
    (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'(RST_CYCLES - 1);

  st_e           st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          skip_q, skip_d;
  logic [15:0]   ret_q, ret_d;
  logic          bp_hit;

  // Skip lets a resumed run execute the instruction it
  // stopped on instead of re-hitting the breakpoint.
  assign bp_hit = bp_en && (cpu_adr == bp_addr)
                  && !skip_q;

  always_comb begin
    cpu_ce   = 1'b0;
    ld_ready = 1'b0;
    unique case (st_q)
      ST_HOLD: cpu_ce = 1'b0;
      ST_HALT: ld_ready = 1'b1;
      ST_RUN:  cpu_ce = !bp_hit;
      ST_STEP: cpu_ce = 1'b1;
    endcase
  end

  assign cpu_rst_n = (st_q != ST_HOLD);
  assign state     = st_q;
  assign retired   = ret_q;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    skip_d = skip_q;
    ret_d  = ret_q;
    if (cpu_ce) begin
      ret_d  = ret_q + 16'd1;
      skip_d = 1'b0;
    end
    if (cmd_rst_cpu) begin
      st_d  = ST_HOLD;
      cnt_d = CNT_INIT;
    end else begin
      unique case (st_q)
        ST_HOLD: begin
          if (cnt_q == '0) st_d = ST_HALT;
          else cnt_d = cnt_q - 1'b1;
        end
        ST_HALT: begin
          if (cmd_halt) begin
            st_d = ST_HALT;
          end else if (cmd_step) begin
            st_d   = ST_STEP;
            skip_d = 1'b1;
          end else if (cmd_run) begin
            st_d   = ST_RUN;
            skip_d = 1'b1;
          end
        end
        ST_RUN: begin
          if (cmd_halt || bp_hit) st_d = ST_HALT;
        end
        ST_STEP: st_d = ST_HALT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= ST_HOLD;
      cnt_q  <= CNT_INIT;
      skip_q <= 1'b0;
      ret_q  <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      skip_q <= skip_d;
      ret_q  <= ret_d;
    end
  end

  dl166_prog_ram u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ld_valid && ld_ready),
    .waddr (ld_addr),
    .wdata (ld_data),
    .raddr (cpu_adr),
    .rdata (cpu_dout)
  );

endmodule

// File: tb/tb_dl166_run_ctrl.sv
// Scoreboard bench for dl166_run_ctrl: directed phases from
// the test plan plus random commands vs. a behavioural model.
module tb_dl166_run_ctrl;

  localparam int RC = 4;

  logic        clk = 1'b0;
  logic        reset, cmd_run, cmd_halt, cmd_step;
  logic        cmd_rst_cpu, ld_valid, ld_ready, bp_en;
  logic [3:0]  ld_addr, bp_addr, cpu_adr;
  logic [7:0]  ld_data, cpu_dout;
  logic        cpu_ce, cpu_rst_n;
  logic [1:0]  state;
  logic [15:0] retired;

  always #5 clk = ~clk;

  dl166_run_ctrl #(.RST_CYCLES(RC)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_run     (cmd_run),
    .cmd_halt    (cmd_halt),
    .cmd_step    (cmd_step),
    .cmd_rst_cpu (cmd_rst_cpu),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .cpu_adr     (cpu_adr),
    .cpu_dout    (cpu_dout),
    .cpu_ce      (cpu_ce),
    .cpu_rst_n   (cpu_rst_n),
    .state       (state),
    .retired     (retired)
  );

  typedef struct packed {
    bit       rst, run, halt, step, rcpu, ldv;
    bit [3:0] lda;
    bit [7:0] ldd;
    bit       bpe;
    bit [3:0] bpa;
    bit [3:0] adr;
  } in_t;

  typedef struct packed {
    bit [1:0]  st;
    bit        rn, ce, lr;
    bit [7:0]  dout;
    bit [15:0] ret;
  } exp_t;

  in_t  g, di, pin;
  exp_t pexp, cur;
  exp_t q[$];
  int   errs = 0;
  int   checks = 0;

  // Model: mode 0=HOLD 1=HALT 2=RUN 3=STEP.
  int       m_mode, m_left, m_ret;
  bit       m_skip, m_ok = 0;
  bit [7:0] m_mem [16];
  bit       have_prev = 0, last_ce = 0, follow = 0;
  bit [3:0] pc = 0;

  assign reset       = di.rst;
  assign cmd_run     = di.run;
  assign cmd_halt    = di.halt;
  assign cmd_step    = di.step;
  assign cmd_rst_cpu = di.rcpu;
  assign ld_valid    = di.ldv;
  assign ld_addr     = di.lda;
  assign ld_data     = di.ldd;
  assign bp_en       = di.bpe;
  assign bp_addr     = di.bpa;
  assign cpu_adr     = di.adr;

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exv);
    checks++;
    if (act !== exv) begin
      errs++;
      $display("FAIL %s: got %h expected %h @%0t",
               nm, act, exv, $time);
    end
  endtask

  function automatic exp_t outputs(input in_t i);
    exp_t e;
    bit hit;
    hit = i.bpe && (i.adr == i.bpa) && !m_skip;
    e.st   = 2'(m_mode);
    e.rn   = (m_mode != 0);
    e.lr   = (m_mode == 1);
    e.ce   = (m_mode == 2 && !hit) || (m_mode == 3);
    e.dout = m_mem[i.adr];
    e.ret  = 16'(m_ret);
    return e;
  endfunction

  // Apply the effects of the cycle that just ended.
  task automatic advance();
    if (pin.rst) begin
      m_ok = 1; m_mode = 0; m_left = RC;
      m_skip = 0; m_ret = 0;
      foreach (m_mem[k]) m_mem[k] = 8'h00;
      return;
    end
    if (!m_ok) return;
    if (pexp.ce) begin
      m_ret  = (m_ret + 1) % 65536;
      m_skip = 0;
    end
    if (pexp.lr && pin.ldv) m_mem[pin.lda] = pin.ldd;
    if (pin.rcpu) begin
      m_mode = 0; m_left = RC;
    end else begin
      case (m_mode)
        0: begin
          m_left--;
          if (m_left == 0) m_mode = 1;
        end
        1: begin
          if (pin.halt) m_mode = 1;
          else if (pin.step) begin
            m_mode = 3; m_skip = 1;
          end else if (pin.run) begin
            m_mode = 2; m_skip = 1;
          end
        end
        2: if (pin.halt || !pexp.ce) m_mode = 1;
        default: m_mode = 1;
      endcase
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
      if (have_prev) advance();
      if (follow) begin
        if (last_ce) pc = pc + 4'd1;
        g.adr = pc;
      end
      di = g;
      if (m_ok) begin
        cur = outputs(g);
        q.push_back(cur);
        last_ce = cur.ce;
      end else begin
        last_ce = 0;
      end
      pin = g; pexp = cur; have_prev = 1;
      g.rst = 0; g.run = 0; g.halt = 0;
      g.step = 0; g.rcpu = 0;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("state", 16'(state), 16'(e.st));
      chk("cpu_rst_n", 16'(cpu_rst_n), 16'(e.rn));
      chk("cpu_ce", 16'(cpu_ce), 16'(e.ce));
      chk("ld_ready", 16'(ld_ready), 16'(e.lr));
      chk("cpu_dout", 16'(cpu_dout), 16'(e.dout));
      chk("retired", retired, e.ret);
    end
  end

  initial begin
    int n;
    g = '0; di = '0; pin = '0;
    cur = '0; pexp = '0;

    // Reset and zeroed memory scan.
    g.rst = 1; tick();
    tick(RC);
    tick();
    chk("halt_after_hold", 16'(state), 16'd1);
    for (int a = 0; a < 16; a++) begin
      g.adr = 4'(a); tick();
    end

    // Load in HALT, readable next cycle.
    g.ldv = 1; g.lda = 4'd3; g.ldd = 8'hA5;
    tick();
    g.ldv = 0; g.adr = 4'd3; tick();
    chk("load_a5", 16'(cpu_dout), 16'h00A5);

    // Single step.
    g.step = 1; tick();
    tick(3);
    chk("step_ret", retired, 16'd1);

    // Write attempted during RUN is held off.
    pc = 0; follow = 1; g.bpe = 0;
    g.run = 1; tick();
    g.ldv = 1; g.lda = 4'd3; g.ldd = 8'h5A;
    tick(5);
    g.halt = 1; tick();
    tick();
    g.ldv = 0; tick(2);

    // Breakpoint at 5, then resume through it.
    pc = 0; g.bpe = 1; g.bpa = 4'd5;
    g.run = 1; tick();
    tick(8);
    chk("bp_halt", 16'(state), 16'd1);
    g.run = 1; tick();
    tick(4);
    g.halt = 1; tick();
    tick(2);

    // Halt + rst_cpu together in RUN.
    g.bpe = 0; g.run = 1; tick();
    tick(3);
    g.halt = 1; g.rcpu = 1; tick();
    tick(RC + 2);

    // Random commands.
    for (int i = 0; i < 3000; i++) begin
      g.run  = ($urandom_range(7) == 0);
      g.halt = ($urandom_range(9) == 0);
      g.step = ($urandom_range(7) == 0);
      g.rcpu = ($urandom_range(40) == 0);
      g.rst  = ($urandom_range(300) == 0);
      if ($urandom_range(30) == 0) begin
        g.bpe = 1'($urandom);
        g.bpa = 4'($urandom);
      end
      if ($urandom_range(15) == 0) pc = 4'($urandom);
      if (!g.ldv || (pin.ldv && pexp.lr)) begin
        g.ldv = ($urandom_range(3) == 0);
        g.lda = 4'($urandom);
        g.ldd = 8'($urandom);
      end
      tick();
    end

    // Retired counter wrap.
    g = '0; follow = 1; pc = 0;
    g.rst = 1; tick();
    tick(RC + 1);
    g.run = 1; tick();
    n = 0;
    while (m_ret != 16'hFFFD && n < 70000) begin
      tick(); n++;
    end
    if (n >= 70000) begin
      errs++;
      $display("FAIL wrap_budget: got %0d cycles", n);
    end
    g.halt = 1; tick();
    tick();
    chk("ret_ffff", retired, 16'hFFFF);
    g.step = 1; tick();
    tick(2);
    chk("ret_wrap", retired, 16'h0000);
    chk("wrap_state", 16'(state), 16'd1);

    @(negedge clk); #1;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d left expected 0",
               q.size());
    end
    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule

// File: doc/dl166_run_ctrl.md
# dl166_run_ctrl

- Run/debug controller for the DL166 4-bit core.
- Owns the 16×8 program memory and shares it between host loading and core instruction fetch.
- Sequences execution through a reset-hold / halt / run / single-step state machine, driving the core's active-low reset and a per-cycle clock enable.
- Sits between the board host interface (buttons/UART bridge) and the core.

## Interface
- `RST_CYCLES`, default 4: cycles `cpu_rst_n` is held low after any reset request (≥1).
- `clk` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `cmd_run` in 1: one-cycle pulse; start free-running from HALT.
- `cmd_halt` in 1: one-cycle pulse; stop after the current cycle.
- `cmd_step` in 1: one-cycle pulse; execute exactly one instruction from HALT.
- `cmd_rst_cpu` in 1: one-cycle pulse; re-enter the reset-hold sequence.
- `ld_valid` in 1: host program-write request.
- `ld_ready` out 1: write accepted when `ld_valid && ld_ready`.
- `ld_addr` in 4: program word address.
- `ld_data` in 8: instruction byte.
- `bp_en` in 1: breakpoint enable.
- `bp_addr` in 4: breakpoint PC.
- `cpu_adr` in 4: core PC.
- `cpu_dout` out 8: instruction at `cpu_adr`.
- `cpu_ce` out 1: core executes an instruction this cycle when high.
- `cpu_rst_n` out 1: active-low reset to the core.
- `state` out 2: `0`=HOLD, `1`=HALT, `2`=RUN, `3`=STEP.
- `retired` out 16: count of cycles with `cpu_ce=1`; wraps at 0xFFFF→0x0000.

## Operation
- **HOLD.**
  - `cpu_rst_n=0`, `cpu_ce=0`, `ld_ready=0`.
  - A down-counter loaded with `RST_CYCLES-1` counts to 0, then the block goes to HALT.
  - Commands are ignored.
- **HALT.**
  - `cpu_rst_n=1`, `cpu_ce=0`, `ld_ready=1`.
  - `cmd_run` goes to RUN; `cmd_step` goes to STEP.
- **RUN.**
  - `cpu_ce = !bp_hit`.
  - `bp_hit = bp_en && cpu_adr==bp_addr && !bp_skip`.
  - On `bp_hit` the block goes to HALT, and the instruction at `bp_addr` is not executed.
  - `cmd_halt` goes to HALT. The instruction in the cycle that `cmd_halt` is sampled still executes (`cpu_ce` is not gated by `cmd_halt`).
- **bp_skip.**
  - Set on every HALT→RUN or HALT→STEP transition.
  - Cleared after the first `cpu_ce=1` cycle.
  - Effect: resuming from a breakpoint executes that instruction rather than re-halting.
- **STEP.**
  - `cpu_ce=1` for exactly one cycle, breakpoint ignored, then HALT.
- **Command priority** (same cycle): `cmd_rst_cpu` > `cmd_halt` > `cmd_step` > `cmd_run`.
  - `cmd_rst_cpu` goes to HOLD from any state, including mid-RUN and mid-HOLD (the counter reloads).
  - `cmd_run`/`cmd_step` outside HALT are ignored.
- **Program memory.**
  - 16×8, asynchronous read: `cpu_dout = mem[cpu_adr]`, combinational.
  - Synchronous write on `ld_valid && ld_ready`.
  - A write to address A in cycle N is visible on `cpu_dout` for `cpu_adr==A` in cycle N+1.
  - `ld_ready=0` outside HALT; the host holds `ld_valid`/`ld_addr`/`ld_data` stable until accepted.
- **`retired`.**
  - Increments in any cycle with `cpu_ce=1`.
  - Cleared by `reset` only (not by `cmd_rst_cpu`).

## Timing
- **Reset values** on `reset`:
  - `state`=HOLD, `cpu_rst_n=0`, `cpu_ce=0`, `ld_ready=0`.
  - `retired`=0, `bp_skip`=0, all memory words = 0x00.
- **HOLD duration:** exactly `RST_CYCLES` cycles with `cpu_rst_n=0`. HALT is entered on the edge after the last one.
- **Command latency:** a command sampled at edge N changes `state` at edge N; the new outputs are valid in the following cycle.
- **Combinational paths:** `cpu_ce` and `ld_ready` are combinational from the registered `state` plus `cpu_adr`/`bp_*`. There is no path from `cmd_*`.
- **Step timing:** STEP occupies one cycle. HALT→STEP→HALT is 2 edges after `cmd_step`.

## Structure
- **Shared package `dl166_pkg`:**
  - State encoding constants (`ST_HOLD`, `ST_HALT`, `ST_RUN`, `ST_STEP`).
  - Instruction width (8) and address width (4).
  - Opcode field constants shared with the core.
- **Sub-module `dl166_prog_ram`:** 16×8 memory with one synchronous write port, one asynchronous read port, and synchronous clear on `reset`.
- **`dl166_run_ctrl`:** holds the FSM, HOLD counter, `bp_skip` flag and `retired` counter.

## Test plan
- **Reset:** assert `reset` 1 cycle, `RST_CYCLES=4` → `cpu_rst_n` low for 4 cycles, `state`=1, `ld_ready=1`, `retired=0`, all `cpu_dout` reads = 0x00.
- **Load:** write 0xA5 to addr 3 in HALT → `ld_ready=1`, `cpu_adr=3` reads 0xA5 the next cycle. Same write during RUN → `ld_ready=0`, memory unchanged.
- **Step:** `cmd_step` in HALT → exactly one `cpu_ce=1` cycle, `retired` 0→1, `state` returns to 1.
- **Breakpoint:** `bp_en=1`, `bp_addr=5`, `cmd_run`, PC reaching 5 → `cpu_ce=0` at PC 5, `state`=1. A second `cmd_run` → the instruction at 5 executes and PC advances.
- **Priority:** `cmd_halt` and `cmd_rst_cpu` in the same RUN cycle → `state`=HOLD, `cpu_rst_n=0` for 4 cycles, `retired` retained.
- **Wrap:** preload `retired`=0xFFFF via 65535 RUN cycles, one more step → `retired`=0x0000.
